// File: rtl/decode_imm_ctrl_pkg.sv
// Shared opcode constants, immediate-format and skid-state enums for the decode controller.
package decode_imm_ctrl_pkg;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef enum logic [1:0] {
        IMM_I     = 2'b00,
        IMM_SHAMT = 2'b01,
        IMM_S     = 2'b10,
        IMM_U     = 2'b11
    } imm_type_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b10
    } skid_state_e;

endpackage

// File: rtl/decode_imm_ctrl_if.sv
// Fetch, immediate-generator and execute-side signals of the decode controller.
// master is the controller's view; slave is the surrounding pipeline's view.
interface decode_imm_ctrl_if #(
    parameter int DATA_WIDTH   = 64,
    parameter int INST_WIDTH   = 32,
    parameter int IMM_TYPE_NUM = 4
);
    localparam int IMM_W = $clog2(IMM_TYPE_NUM);

    logic                  if_valid;
    logic                  if_ready;
    logic [INST_WIDTH-1:0] if_inst;
    logic [DATA_WIDTH-1:0] if_pc;

    logic [INST_WIDTH-1:0] gen_inst;
    logic [IMM_W-1:0]      gen_imm_type;
    logic [DATA_WIDTH-1:0] gen_imm;

    logic                  id_valid;
    logic                  id_ready;
    logic [INST_WIDTH-1:0] id_inst;
    logic [DATA_WIDTH-1:0] id_pc;
    logic [DATA_WIDTH-1:0] id_imm;
    logic                  id_uses_imm;
    logic                  id_illegal;

    modport master (
        input  if_valid, if_inst, if_pc, gen_imm, id_ready,
        output if_ready, gen_inst, gen_imm_type,
               id_valid, id_inst, id_pc, id_imm, id_uses_imm, id_illegal
    );

    modport slave (
        output if_valid, if_inst, if_pc, gen_imm, id_ready,
        input  if_ready, gen_inst, gen_imm_type,
               id_valid, id_inst, id_pc, id_imm, id_uses_imm, id_illegal
    );
endinterface

// File: rtl/decode_imm_ctrl_class.sv
// Pure combinational opcode/funct3 classifier selecting immediate format and operand-B source.
module decode_imm_class
    import decode_imm_ctrl_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    output imm_type_e  imm_type_o,
    output logic       uses_imm_o,
    output logic       illegal_o
);

    always_comb begin
        imm_type_o = IMM_I;
        uses_imm_o = 1'b0;
        illegal_o  = 1'b0;
        case (opcode_i)
            OPC_OP_IMM: begin
                imm_type_o = (funct3_i == 3'b001 || funct3_i == 3'b101) ? IMM_SHAMT : IMM_I;
                uses_imm_o = 1'b1;
            end
            OPC_LOAD, OPC_JALR: begin
                imm_type_o = IMM_I;
                uses_imm_o = 1'b1;
            end
            OPC_STORE: begin
                imm_type_o = IMM_S;
                uses_imm_o = 1'b1;
            end
            OPC_LUI, OPC_AUIPC: begin
                imm_type_o = IMM_U;
                uses_imm_o = 1'b1;
            end
            // Branch offsets are computed by the branch unit, not operand B.
            OPC_OP, OPC_BRANCH, OPC_JAL: begin
                imm_type_o = IMM_I;
                uses_imm_o = 1'b0;
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/decode_imm_ctrl.sv
// Decode-stage controller: 2-entry skid buffer, opcode classification and immediate-generator drive.
// Optional performance counters enabled by defining DECODE_PERF_EN.
module decode_imm_ctrl
    import decode_imm_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH   = 64,
    parameter int INST_WIDTH   = 32,
    parameter int IMM_TYPE_NUM = 4
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               flush_i,
    decode_imm_ctrl_if.master  bus
`ifdef DECODE_PERF_EN
    ,
    output logic [31:0]        perf_stall_cnt_o,
    output logic [31:0]        perf_illegal_cnt_o
`endif
);

    localparam int IMM_W = $clog2(IMM_TYPE_NUM);

    skid_state_e           state_q, state_d;
    logic [INST_WIDTH-1:0] headInst_q, headInst_d;
    logic [DATA_WIDTH-1:0] headPc_q, headPc_d;
    logic [INST_WIDTH-1:0] skidInst_q, skidInst_d;
    logic [DATA_WIDTH-1:0] skidPc_q, skidPc_d;
    logic                  ifReady_q;

    logic                  headValid;
    logic                  accept;
    logic                  retire;
    imm_type_e             classType;
    logic                  classUsesImm;
    logic                  classIllegal;

    assign headValid = (state_q != ST_EMPTY);
    assign accept    = bus.if_valid && ifReady_q;
    assign retire    = headValid && bus.id_ready;

    always_comb begin
        state_d    = state_q;
        headInst_d = headInst_q;
        headPc_d   = headPc_q;
        skidInst_d = skidInst_q;
        skidPc_d   = skidPc_q;
        // Flush drops any accept; a concurrent retire has already been seen by execute.
        if (flush_i) begin
            state_d    = ST_EMPTY;
            headInst_d = '0;
            headPc_d   = '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d    = ST_ONE;
                        headInst_d = bus.if_inst;
                        headPc_d   = bus.if_pc;
                    end
                end
                ST_ONE: begin
                    if (accept && retire) begin
                        headInst_d = bus.if_inst;
                        headPc_d   = bus.if_pc;
                    end else if (accept) begin
                        state_d    = ST_FULL;
                        skidInst_d = bus.if_inst;
                        skidPc_d   = bus.if_pc;
                    end else if (retire) begin
                        state_d    = ST_EMPTY;
                        headInst_d = '0;
                        headPc_d   = '0;
                    end
                end
                ST_FULL: begin
                    if (retire) begin
                        state_d    = ST_ONE;
                        headInst_d = skidInst_q;
                        headPc_d   = skidPc_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // if_ready is registered from next state so id_ready never reaches it combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            headInst_q <= '0;
            headPc_q   <= '0;
            skidInst_q <= '0;
            skidPc_q   <= '0;
            ifReady_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            headInst_q <= headInst_d;
            headPc_q   <= headPc_d;
            skidInst_q <= skidInst_d;
            skidPc_q   <= skidPc_d;
            ifReady_q  <= (state_d != ST_FULL);
        end
    end

    decode_imm_class uClass (
        .opcode_i   (headInst_q[6:0]),
        .funct3_i   (headInst_q[14:12]),
        .imm_type_o (classType),
        .uses_imm_o (classUsesImm),
        .illegal_o  (classIllegal)
    );

    assign bus.if_ready     = ifReady_q;
    assign bus.gen_inst     = headInst_q;
    assign bus.gen_imm_type = headValid ? IMM_W'(classType) : '0;
    assign bus.id_valid     = headValid;
    assign bus.id_inst      = headInst_q;
    assign bus.id_pc        = headPc_q;
    assign bus.id_imm       = bus.gen_imm;
    assign bus.id_uses_imm  = headValid && classUsesImm;
    assign bus.id_illegal   = headValid && classIllegal;

`ifdef DECODE_PERF_EN
    logic [31:0] perfStall_q;
    logic [31:0] perfIllegal_q;

    // Both counters saturate rather than wrap; only reset clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perfStall_q   <= '0;
            perfIllegal_q <= '0;
        end else begin
            if (headValid && !bus.id_ready && perfStall_q != 32'hFFFF_FFFF)
                perfStall_q <= perfStall_q + 32'd1;
            if (retire && bus.id_illegal && perfIllegal_q != 32'hFFFF_FFFF)
                perfIllegal_q <= perfIllegal_q + 32'd1;
        end
    end

    assign perf_stall_cnt_o   = perfStall_q;
    assign perf_illegal_cnt_o = perfIllegal_q;
`endif

endmodule
